uncached_write_buffer: RTL and testbench

UNCACHED_WRITE_BUFFER -- requirements
Module: uncached_write_buffer

---
 rtl/uncached_write_buffer_pkg.sv | 55 +++++
 rtl/wbuf_fifo.sv | 92 +++++++++
 rtl/uncached_write_buffer.sv | 157 +++++++++++++++
 tb/tb_uncached_write_buffer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uncached_write_buffer_pkg.sv
// Shared types for the uncached write buffer: bus request/response structs,
// the buffered store entry, the load FSM state enum and the default depth.
// Purely declarative; no logic or timing lives here.
package uncached_write_buffer_pkg;

    localparam int WBUF_DEPTH_DEFAULT = 4;

    // Only single-beat transfers are ever issued from this block.
    localparam logic [3:0] CBUS_LEN_SINGLE = 4'd0;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_DRAIN = 2'd1,
        LD_LOAD  = 2'd2,
        LD_RESP  = 2'd3
    } load_state_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Purpose: circular store buffer of DEPTH wbuf_entry_t entries for the uncached write path.
// Latency: a pushed entry is visible on head the cycle after the push edge when the buffer was empty.
// Backpressure: push is ignored while full, pop is ignored while empty; a same-cycle pop does not free a slot for the push.
// Ports: clk/reset (async, active-high); push/push_entry enqueue; pop dequeues head;
//        full/empty/count report occupancy; head is the oldest entry.
// With UNCACHED_WBUF_FWD_EN defined, lookup_addr/lookup_hit/lookup_data expose a
// youngest-match word-address search used for store-to-load forwarding.
module wbuf_fifo
    import uncached_write_buffer_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wbuf_entry_t            push_entry,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output wbuf_entry_t            head,
    output logic [$clog2(DEPTH):0] count
`ifdef UNCACHED_WBUF_FWD_EN
    ,
    input  logic [31:0]            lookup_addr,
    output logic                   lookup_hit,
    output logic [31:0]            lookup_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    wbuf_entry_t   mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[head_ptr];

    // Entry storage carries no reset: only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail_ptr] <= push_entry;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef UNCACHED_WBUF_FWD_EN
    logic [PW-1:0] scan_idx;

    // Walk live entries oldest to youngest so the youngest word match wins;
    // a partial-strobe youngest match suppresses the hit entirely.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        scan_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_ptr + PW'(i);
            if (((PW+1)'(i) < count) && (mem[scan_idx].addr[31:2] == lookup_addr[31:2])) begin
                lookup_hit  = (mem[scan_idx].strobe == 4'hF);
                lookup_data = mem[scan_idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/uncached_write_buffer.sv
// Purpose: posts uncached stores into a small FIFO drained as single-beat cbus writes; loads wait for the FIFO to drain, then issue one cbus read.
// Latency: store addr_ok same cycle, data_ok next cycle; load answers one cycle after its cbus read completes.
// Backpressure: stores refused while full or while a load is in flight; oreq is held stable until ready && last.
// Ports: clk, reset (async, active-high); dreq/dresp = core data bus;
//        oreq/oresp = single-beat port toward the cbus arbiter.
// Optional: UNCACHED_WBUF_FWD_EN enables forwarding a load from the youngest full-word buffered store.
module uncached_write_buffer
    import uncached_write_buffer_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    load_state_t            state;
    logic [31:0]            ld_addr;
    logic [1:0]             ld_size;
    logic [31:0]            ld_data;
    logic                   store_ack;

    logic                   is_store;
    logic                   is_load;
    logic                   store_accept;
    logic                   bus_done;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    wbuf_entry_t            push_entry;
    wbuf_entry_t            head;

`ifdef UNCACHED_WBUF_FWD_EN
    logic                   fwd_hit;
    logic [31:0]            fwd_data;
`endif

    assign is_store = dreq.valid && (dreq.strobe != 4'h0);
    assign is_load  = dreq.valid && (dreq.strobe == 4'h0);

    // Stores only enter while no load is pending; this keeps program order.
    assign store_accept = !reset && (state == LD_IDLE) && is_store && !full;

    assign bus_done = oresp.ready && oresp.last;
    // While the buffer holds entries, the bus carries the head write.
    assign pop      = !empty && bus_done;

    assign push_entry.addr   = dreq.addr;
    assign push_entry.size   = dreq.size;
    assign push_entry.strobe = dreq.strobe;
    assign push_entry.data   = dreq.data;

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (store_accept),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .count      (count)
`ifdef UNCACHED_WBUF_FWD_EN
        ,
        .lookup_addr (dreq.addr),
        .lookup_hit  (fwd_hit),
        .lookup_data (fwd_data)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LD_IDLE;
            ld_addr   <= '0;
            ld_size   <= '0;
            ld_data   <= '0;
            store_ack <= 1'b0;
        end else begin
            store_ack <= store_accept;
            case (state)
                LD_IDLE: begin
                    if (is_load) begin
                        ld_addr <= dreq.addr;
                        ld_size <= dreq.size;
`ifdef UNCACHED_WBUF_FWD_EN
                        if (fwd_hit) begin
                            ld_data <= fwd_data;
                            state   <= LD_RESP;
                        end else
`endif
                        if (empty) begin
                            state <= LD_LOAD;
                        end else begin
                            state <= LD_DRAIN;
                        end
                    end
                end
                LD_DRAIN: begin
                    if (count == '0) begin
                        state <= LD_LOAD;
                    end
                end
                LD_LOAD: begin
                    // Buffer is empty here, so this handshake belongs to the read.
                    if (bus_done) begin
                        ld_data <= oresp.data;
                        state   <= LD_RESP;
                    end
                end
                LD_RESP: begin
                    state <= LD_IDLE;
                end
                default: begin
                    state <= LD_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dresp = '0;
        oreq  = '0;
        if (!reset) begin
            if (state == LD_RESP) begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
                dresp.data    = ld_data;
            end else begin
                dresp.addr_ok = store_accept;
                dresp.data_ok = store_ack;
            end

            if (!empty) begin
                oreq.valid    = 1'b1;
                oreq.is_write = 1'b1;
                oreq.size     = head.size;
                oreq.addr     = head.addr;
                oreq.strobe   = head.strobe;
                oreq.data     = head.data;
                oreq.len      = CBUS_LEN_SINGLE;
            end else if (state == LD_LOAD) begin
                oreq.valid    = 1'b1;
                oreq.is_write = 1'b0;
                oreq.size     = ld_size;
                oreq.addr     = ld_addr;
                oreq.len      = CBUS_LEN_SINGLE;
            end
        end
    end

endmodule

// File: tb/tb_uncached_write_buffer.sv
module tb_uncached_write_buffer;
    import uncached_write_buffer_pkg::*;

    localparam int DEPTH   = 4;
    localparam int PH_NONE = 0;  // no load outstanding
    localparam int PH_WAIT = 1;  // load waiting for older stores to leave
    localparam int PH_READ = 2;  // load on the bus
    localparam int PH_RESP = 3;  // load answer presented to the core

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    always #5 clk = ~clk;

    uncached_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp)
    );

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Reference model: queue of posted stores plus the outstanding load.
    wbuf_entry_t mq[$];
    int          ph;
    logic [31:0] m_laddr;
    logic [1:0]  m_lsize;
    logic [31:0] m_ldata;
    bit          m_ack;
    bit          taken;

    // Log of completed bus transactions, as seen by the model.
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    bit          log_wr[$];

    logic        e_addr_ok;
    logic        e_data_ok;
    cbus_req_t   e_oreq;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        mq.delete();
        ph      = PH_NONE;
        m_laddr = '0;
        m_lsize = '0;
        m_ldata = '0;
        m_ack   = 1'b0;
        taken   = 1'b0;
    endfunction

    function automatic void log_clear();
        log_addr.delete();
        log_data.delete();
        log_wr.delete();
    endfunction

    function automatic void eval_model();
        e_oreq    = '0;
        e_addr_ok = 1'b0;
        e_data_ok = 1'b0;
        if (!reset) begin
            if (mq.size() > 0) begin
                e_oreq.valid    = 1'b1;
                e_oreq.is_write = 1'b1;
                e_oreq.addr     = mq[0].addr;
                e_oreq.size     = mq[0].size;
                e_oreq.strobe   = mq[0].strobe;
                e_oreq.data     = mq[0].data;
                e_oreq.len      = 4'd0;
            end else if (ph == PH_READ) begin
                e_oreq.valid    = 1'b1;
                e_oreq.is_write = 1'b0;
                e_oreq.addr     = m_laddr;
                e_oreq.size     = m_lsize;
                e_oreq.len      = 4'd0;
            end
            if (ph == PH_RESP) begin
                e_addr_ok = 1'b1;
                e_data_ok = 1'b1;
            end else begin
                e_addr_ok = (ph == PH_NONE) && dreq.valid && (dreq.strobe != 4'h0) && (mq.size() < DEPTH);
                e_data_ok = m_ack;
            end
        end
    endfunction

    // Advance the model across one rising edge, using the inputs that were stable before it.
    function automatic void model_advance();
        bit          hs;
        bit          acc;
        bit          is_ld;
        int          pre;
        wbuf_entry_t ent;
`ifdef UNCACHED_WBUF_FWD_EN
        int          hit;
`endif
        if (reset) begin
            model_clear();
            return;
        end
        eval_model();
        pre   = mq.size();
        hs    = e_oreq.valid && oresp.ready && oresp.last;
        acc   = e_addr_ok && (ph == PH_NONE);
        taken = e_addr_ok;
        is_ld = dreq.valid && (dreq.strobe == 4'h0);
        case (ph)
            PH_NONE: begin
                if (is_ld) begin
                    m_laddr = dreq.addr;
                    m_lsize = dreq.size;
                    ph = (pre == 0) ? PH_READ : PH_WAIT;
`ifdef UNCACHED_WBUF_FWD_EN
                    hit = -1;
                    for (int i = 0; i < pre; i++) begin
                        ent = mq[i];
                        if (ent.addr[31:2] == dreq.addr[31:2]) hit = i;
                    end
                    if (hit >= 0) begin
                        ent = mq[hit];
                        if (ent.strobe == 4'hF) begin
                            m_ldata = ent.data;
                            ph = PH_RESP;
                        end
                    end
`endif
                end
            end
            PH_WAIT: if (pre == 0) ph = PH_READ;
            PH_READ: if (hs) begin
                m_ldata = oresp.data;
                ph = PH_RESP;
            end
            default: ph = PH_NONE;
        endcase
        if (hs) begin
            log_addr.push_back(e_oreq.addr);
            log_wr.push_back(e_oreq.is_write);
            log_data.push_back(e_oreq.is_write ? e_oreq.data : oresp.data);
            if (e_oreq.is_write) void'(mq.pop_front());
        end
        if (acc) begin
            ent.addr   = dreq.addr;
            ent.size   = dreq.size;
            ent.strobe = dreq.strobe;
            ent.data   = dreq.data;
            mq.push_back(ent);
        end
        m_ack = acc;
    endfunction

    // Per-cycle compare of every DUT output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                eval_model();
                cmp("addr_ok", 32'(dresp.addr_ok), 32'(e_addr_ok));
                cmp("data_ok", 32'(dresp.data_ok), 32'(e_data_ok));
                if (ph == PH_RESP && !reset) cmp("resp_data", dresp.data, m_ldata);
                cmp("oreq_valid", 32'(oreq.valid), 32'(e_oreq.valid));
                if (e_oreq.valid) begin
                    cmp("oreq_is_write", 32'(oreq.is_write), 32'(e_oreq.is_write));
                    cmp("oreq_addr", oreq.addr, e_oreq.addr);
                    cmp("oreq_size", 32'(oreq.size), 32'(e_oreq.size));
                    cmp("oreq_len", 32'(oreq.len), 32'(e_oreq.len));
                    if (e_oreq.is_write) begin
                        cmp("oreq_strobe", 32'(oreq.strobe), 32'(e_oreq.strobe));
                        cmp("oreq_data", oreq.data, e_oreq.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "tb timeout");
    end

    task automatic cyc();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d,
                        input int budget, output int n);
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = 2'd2;
        dreq.strobe = st;
        dreq.data   = d;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!taken && n < budget);
        if (!taken) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: addr %h got no addr_ok within %0d cycles", a, budget);
        end
        dreq = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((mq.size() != 0 || ph != PH_NONE || m_ack) && n < budget) begin
            cyc();
            n++;
        end
        if (mq.size() != 0 || ph != PH_NONE || m_ack) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: still busy after %0d cycles", budget);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        dreq  = '0;
        oresp = '0;
        model_clear();
        chk_on = 1'b1;

        // A store offered during reset must be ignored.
        dreq.valid  = 1'b1;
        dreq.addr   = 32'h1FD0_0000;
        dreq.size   = 2'd2;
        dreq.strobe = 4'hF;
        dreq.data   = 32'h1111_1111;
        repeat (3) cyc();
        cmp("rst_addr_ok", 32'(dresp.addr_ok), 32'd0);
        cmp("rst_data_ok", 32'(dresp.data_ok), 32'd0);
        cmp("rst_oreq_valid", 32'(oreq.valid), 32'd0);
        dreq  = '0;
        reset = 1'b0;
        cyc();

        // Four stores, arbiter always ready.
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        log_clear();
        for (int i = 0; i < 4; i++) begin
            send(32'h1FD0_0000 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i), 8, n);
            cmp("s1_store_lat", 32'(n), 32'd1);
        end
        wait_idle(40);
        cmp("s1_nwrites", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            cmp("s1_wr_addr", log_addr[i], 32'h1FD0_0000 + 32'(i * 4));
            cmp("s1_wr_flag", 32'(log_wr[i]), 32'd1);
        end
        cmp("s1_oreq_idle", 32'(oreq.valid), 32'd0);

        // Five back-to-back stores with arbiter stalled.
        oresp.ready = 1'b0;
        oresp.last  = 1'b0;
        log_clear();
        for (int i = 0; i < 4; i++) begin
            send(32'h1FD0_0100 + 32'(i * 4), 4'hF, 32'hB000_0000 + 32'(i), 4, n);
            cmp("s2_store_lat", 32'(n), 32'd1);
        end
        dreq.valid  = 1'b1;
        dreq.addr   = 32'h1FD0_0110;
        dreq.size   = 2'd2;
        dreq.strobe = 4'hF;
        dreq.data   = 32'hB000_0004;
        repeat (4) begin
            cyc();
            cmp("s2_full_addr_ok", 32'(dresp.addr_ok), 32'd0);
        end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        // The first pop edge still sees a full buffer; the slot frees one cycle later.
        send(32'h1FD0_0110, 4'hF, 32'hB000_0004, 10, n);
        cmp("s2_fifth_lat", 32'(n), 32'd2);
        wait_idle(40);
        cmp("s2_nwrites", 32'(log_addr.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
            cmp("s2_wr_addr", log_addr[i], 32'h1FD0_0100 + 32'(i * 4));
            cmp("s2_wr_data", log_data[i], 32'hB000_0000 + 32'(i));
        end

        // Two stores then a load: the read follows both writes.
        log_clear();
        oresp.data = 32'hDEAD_BEEF;
        send(32'h1FD0_0200, 4'hF, 32'hC000_0000, 4, n);
        send(32'h1FD0_0204, 4'h3, 32'hC000_0001, 4, n);
        send(32'h1FD0_0010, 4'h0, 32'h0, 20, n);
        cmp("s3_load_lat", 32'(n), 32'd4);
        cmp("s3_rdata", m_ldata, 32'hDEAD_BEEF);
        cmp("s3_ntrans", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            cmp("s3_first_wr", 32'(log_wr[0]), 32'd1);
            cmp("s3_second_wr", 32'(log_wr[1]), 32'd1);
            cmp("s3_read_last", 32'(log_wr[2]), 32'd0);
            cmp("s3_read_addr", log_addr[2], 32'h1FD0_0010);
        end
        wait_idle(20);

        // Load with empty buffer.
        log_clear();
        oresp.data = 32'h1234_5678;
        send(32'h1FD0_0040, 4'h0, 32'h0, 10, n);
        cmp("s4_load_lat", 32'(n), 32'd3);
        cmp("s4_rdata", m_ldata, 32'h1234_5678);
        cmp("s4_ntrans", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) cmp("s4_is_read", 32'(log_wr[0]), 32'd0);
        wait_idle(20);

`ifdef UNCACHED_WBUF_FWD_EN
        // Forwarding from a stalled full-word store.
        oresp.ready = 1'b0;
        oresp.last  = 1'b0;
        log_clear();
        send(32'h1FD0_0020, 4'hF, 32'hCAFE_F00D, 4, n);
        send(32'h1FD0_0020, 4'h0, 32'h0, 6, n);
        cmp("s5_fwd_lat", 32'(n), 32'd2);
        cmp("s5_fwd_data", m_ldata, 32'hCAFE_F00D);
        cmp("s5_no_bus", 32'(log_addr.size()), 32'd0);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        wait_idle(20);
        cmp("s5_one_write", 32'(log_addr.size()), 32'd1);
`endif

        // Reset with three buffered stores.
        oresp.ready = 1'b0;
        oresp.last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'h1FD0_0300 + 32'(i * 4), 4'hF, 32'hD000_0000 + 32'(i), 4, n);
        end
        cyc();
        cmp("s6_busy", 32'(oreq.valid), 32'd1);
        reset = 1'b1;
        model_clear();
        #1;
        cmp("s6_rst_oreq", 32'(oreq.valid), 32'd0);
        repeat (2) cyc();
        reset = 1'b0;
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        log_clear();
        repeat (10) cyc();
        cmp("s6_no_writes", 32'(log_addr.size()), 32'd0);
        cmp("s6_oreq_idle", 32'(oreq.valid), 32'd0);

        // Randomized traffic over a small address window with a reset pulse mid-run.
        for (int c = 0; c < 2500; c++) begin
            if (c == 1200) begin
                reset = 1'b1;
                model_clear();
                dreq = '0;
            end
            if (c == 1203) reset = 1'b0;
            if (!reset && (!dreq.valid || taken)) begin
                dreq = '0;
                if ($urandom_range(0, 9) < 6) begin
                    dreq.valid = 1'b1;
                    dreq.size  = 2'd2;
                    dreq.addr  = 32'h1FD0_0000 + ($urandom_range(0, 7) << 2);
                    dreq.data  = $urandom();
                    if ($urandom_range(0, 3) != 0)
                        dreq.strobe = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(1, 15));
                    else
                        dreq.strobe = 4'h0;
                end
            end
            oresp.ready = 1'($urandom_range(0, 1));
            oresp.last  = oresp.ready;
            oresp.data  = $urandom();
            cyc();
        end
        dreq = '0;
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        wait_idle(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
